timed_flag_sequencer: RTL and testbench

//   Multi-channel, clocked generator of ordered flag events: on a start pulse a

---
 rtl/timed_flag_sequencer.sv | 113 +++++++++++
 tb/tb_timed_flag_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timed_flag_sequencer.sv
// Multi-channel ordered flag generator: each channel clears flag_b on start, raises
// flag_a after delay_a cycles, then raises flag_b (with a done pulse) after delay_b more.
module timed_flag_sequencer #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter bit RETRIGGER = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] start,
    input  logic [CNT_W-1:0]    delay_a,
    input  logic [CNT_W-1:0]    delay_b,
    output logic [CHANNELS-1:0] flag_a,
    output logic [CHANNELS-1:0] flag_b,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] drop
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PHASE_A = 2'd1,
        ST_PHASE_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] dly_b_reg;
            logic             flag_a_reg;
            logic             flag_b_reg;
            logic             busy_reg;
            logic             done_reg;
            logic             drop_reg;
            logic             cnt_expired;
            logic             restart;
            logic             rejected;

            // A delay of 0 behaves like 1: the phase ends on the first edge.
            assign cnt_expired = (cnt_reg <= CNT_ONE);
            assign restart     = start[gi] && ((state_reg == ST_IDLE) || RETRIGGER);
            assign rejected    = start[gi] && (state_reg != ST_IDLE) && !RETRIGGER;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg  <= ST_IDLE;
                    cnt_reg    <= CNT_ZERO;
                    dly_b_reg  <= CNT_ZERO;
                    flag_a_reg <= 1'b0;
                    flag_b_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b0;
                    drop_reg   <= 1'b0;
                end else begin
                    done_reg <= 1'b0;
                    drop_reg <= rejected;
                    if (restart) begin
                        // Restart takes priority over a completing edge, so no done then.
                        flag_a_reg <= 1'b0;
                        flag_b_reg <= 1'b0;
                        cnt_reg    <= delay_a;
                        dly_b_reg  <= delay_b;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_PHASE_A;
                    end else begin
                        case (state_reg)
                            ST_IDLE: begin
                                busy_reg <= 1'b0;
                            end
                            ST_PHASE_A: begin
                                if (cnt_expired) begin
                                    flag_a_reg <= 1'b1;
                                    cnt_reg    <= dly_b_reg;
                                    state_reg  <= ST_PHASE_B;
                                end else begin
                                    cnt_reg <= cnt_reg - CNT_ONE;
                                end
                            end
                            ST_PHASE_B: begin
                                if (cnt_expired) begin
                                    flag_b_reg <= 1'b1;
                                    done_reg   <= 1'b1;
                                    busy_reg   <= 1'b0;
                                    cnt_reg    <= CNT_ZERO;
                                    state_reg  <= ST_IDLE;
                                end else begin
                                    cnt_reg <= cnt_reg - CNT_ONE;
                                end
                            end
                            default: begin
                                busy_reg  <= 1'b0;
                                cnt_reg   <= CNT_ZERO;
                                state_reg <= ST_IDLE;
                            end
                        endcase
                    end
                end
            end

            assign flag_a[gi] = flag_a_reg;
            assign flag_b[gi] = flag_b_reg;
            assign busy[gi]   = busy_reg;
            assign done[gi]   = done_reg;
            assign drop[gi]   = drop_reg;
        end
    endgenerate

endmodule

// File: tb/tb_timed_flag_sequencer.sv
// Scoreboard bench: expected flag/done/drop events are queued with their edge index
// when a start is driven, and matched as the two DUT instances (drop / retrigger) produce them.
module tb_timed_flag_sequencer;

    localparam int EV_A    = 0;
    localparam int EV_B    = 1;
    localparam int EV_DONE = 2;
    localparam int EV_DROP = 3;

    typedef struct {
        int unit;
        int ch;
        int kind;
        int at;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0][3:0] start_i = '0;
    logic [7:0]      delay_a = '0;
    logic [7:0]      delay_b = '0;
    logic [1:0][3:0] flag_a_o;
    logic [1:0][3:0] flag_b_o;
    logic [1:0][3:0] busy_o;
    logic [1:0][3:0] done_o;
    logic [1:0][3:0] drop_o;
    logic [1:0][3:0] prev_a = '0;
    logic [1:0][3:0] prev_b = '0;

    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    ev_t  exp_q[$];

    timed_flag_sequencer #(.CHANNELS(4), .CNT_W(8), .RETRIGGER(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .delay_a(delay_a), .delay_b(delay_b),
        .flag_a(flag_a_o[0]), .flag_b(flag_b_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .drop(drop_o[0])
    );

    timed_flag_sequencer #(.CHANNELS(4), .CNT_W(8), .RETRIGGER(1'b1)) dut_rt (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .delay_a(delay_a), .delay_b(delay_b),
        .flag_a(flag_a_o[1]), .flag_b(flag_b_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .drop(drop_o[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic string kind_name(input int kind);
        case (kind)
            EV_A:    return "flag_a";
            EV_B:    return "flag_b";
            EV_DONE: return "done";
            default: return "drop";
        endcase
    endfunction

    function automatic int max1(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    task automatic push_ev(input int u, input int c, input int kind, input int at);
        ev_t e;
        e.unit = u; e.ch = c; e.kind = kind; e.at = at;
        exp_q.push_back(e);
    endtask

    // Full sequence started at edge k: flag_a after max(da,1), flag_b/done max(db,1) later.
    task automatic push_seq(input int u, input int c, input int k, input int da, input int db);
        push_ev(u, c, EV_A, k + max1(da));
        push_ev(u, c, EV_B, k + max1(da) + max1(db));
        push_ev(u, c, EV_DONE, k + max1(da) + max1(db));
    endtask

    task automatic match_event(input int u, input int c, input int kind);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].unit == u && exp_q[i].ch == c && exp_q[i].kind == kind) begin
                idx = i;
                break;
            end
        end
        if (idx < 0) begin
            check_val($sformatf("unexpected_%s_u%0d_c%0d", kind_name(kind), u, c), edge_cnt, -1);
        end else begin
            $display("event u%0d c%0d %s at e%0d (expected e%0d)",
                     u, c, kind_name(kind), edge_cnt, exp_q[idx].at);
            check_val($sformatf("%s_u%0d_c%0d", kind_name(kind), u, c), edge_cnt, exp_q[idx].at);
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < 4; c++) begin
                if (flag_a_o[u][c] && !prev_a[u][c]) match_event(u, c, EV_A);
                if (flag_b_o[u][c] && !prev_b[u][c]) match_event(u, c, EV_B);
                if (done_o[u][c]) match_event(u, c, EV_DONE);
                if (drop_o[u][c]) match_event(u, c, EV_DROP);
                if (flag_b_o[u][c]) check_val($sformatf("order_u%0d_c%0d", u, c), int'(flag_a_o[u][c]), 1);
            end
        end
        prev_a = flag_a_o;
        prev_b = flag_b_o;
    end

    // Start pulse sampled at edge tgt; returns at the negedge following that edge.
    task automatic drive_start(input int u, input logic [3:0] mask, input int da, input int db, input int tgt);
        while (edge_cnt < tgt - 1) @(negedge clk);
        delay_a    = 8'(da);
        delay_b    = 8'(db);
        start_i[u] = mask;
        @(negedge clk);
        start_i[u] = '0;
    endtask

    task automatic wait_edge(input int tgt);
        while (edge_cnt < tgt) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_flag_a"}, int'(flag_a_o), 0);
        check_val({tag, "_flag_b"}, int'(flag_b_o), 0);
        check_val({tag, "_busy"}, int'(busy_o), 0);
        check_val({tag, "_done"}, int'(done_o), 0);
        check_val({tag, "_drop"}, int'(drop_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending events, expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 2/2 on channel 0.
        k = edge_cnt + 1;
        push_seq(0, 0, k, 2, 2);
        drive_start(0, 4'b0001, 2, 2, k);
        check_val("basic_busy_e0", int'(busy_o[0][0]), 1);
        check_val("basic_flag_b_e0", int'(flag_b_o[0][0]), 0);
        wait_edge(k + 4);
        check_val("basic_busy_end", int'(busy_o[0][0]), 0);
        check_val("basic_flag_a_level", int'(flag_a_o[0][0]), 1);
        check_val("basic_flag_b_level", int'(flag_b_o[0][0]), 1);
        wait_drain(20);

        // Zero delays, then the maximum delay.
        k = edge_cnt + 1;
        push_seq(0, 1, k, 0, 0);
        drive_start(0, 4'b0010, 0, 0, k);
        wait_drain(20);
        k = edge_cnt + 1;
        push_seq(0, 2, k, 255, 1);
        drive_start(0, 4'b0100, 255, 1, k);
        wait_drain(300);

        // Start while busy without retrigger: dropped, including on the completing edge.
        k = edge_cnt + 1;
        push_seq(0, 0, k, 3, 3);
        drive_start(0, 4'b0001, 3, 3, k);
        push_ev(0, 0, EV_DROP, k + 2);
        drive_start(0, 4'b0001, 7, 7, k + 2);
        push_ev(0, 0, EV_DROP, k + 6);
        drive_start(0, 4'b0001, 7, 7, k + 6);
        wait_edge(k + 7);
        check_val("drop_no_restart_busy", int'(busy_o[0][0]), 0);
        check_val("drop_flag_b_kept", int'(flag_b_o[0][0]), 1);
        wait_drain(20);

        // Retrigger in PHASE_B clears both flags and restarts.
        k = edge_cnt + 1;
        push_ev(1, 0, EV_A, k + 3);
        drive_start(1, 4'b0001, 3, 3, k);
        push_ev(1, 0, EV_A, k + 7);
        push_ev(1, 0, EV_B, k + 10);
        push_ev(1, 0, EV_DONE, k + 10);
        drive_start(1, 4'b0001, 3, 3, k + 4);
        check_val("rt_flag_a_cleared", int'(flag_a_o[1][0]), 0);
        check_val("rt_busy", int'(busy_o[1][0]), 1);
        wait_drain(30);

        // Retrigger on the completing edge: restart wins, no done, flag_b stays low.
        k2 = edge_cnt + 1;
        push_ev(1, 1, EV_A, k2 + 1);
        push_ev(1, 1, EV_A, k2 + 3);
        push_ev(1, 1, EV_B, k2 + 4);
        push_ev(1, 1, EV_DONE, k2 + 4);
        drive_start(1, 4'b0010, 1, 1, k2);
        drive_start(1, 4'b0010, 1, 1, k2 + 2);
        check_val("rt_complete_flag_b", int'(flag_b_o[1][1]), 0);
        check_val("rt_complete_done", int'(done_o[1][1]), 0);
        wait_drain(20);

        // Independent channels with latched delays; inputs changed afterwards.
        k = edge_cnt + 1;
        push_seq(0, 0, k, 1, 5);
        push_seq(0, 3, k + 1, 4, 1);
        drive_start(0, 4'b0001, 1, 5, k);
        drive_start(0, 4'b1000, 4, 1, k + 1);
        delay_a = 8'd200;
        delay_b = 8'd200;
        wait_drain(30);

        // Asynchronous reset mid PHASE_A, then a clean sequence.
        k = edge_cnt + 1;
        drive_start(0, 4'b0010, 10, 3, k);
        wait_edge(k + 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        k = edge_cnt + 1;
        push_seq(0, 1, k, 2, 2);
        drive_start(0, 4'b0010, 2, 2, k);
        wait_drain(20);
        repeat (3) @(negedge clk);

        foreach (exp_q[i])
            check_val($sformatf("missing_%s_u%0d_c%0d", kind_name(exp_q[i].kind), exp_q[i].unit, exp_q[i].ch),
                      -1, exp_q[i].at);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
